pc_ctrl: RTL and testbench

- Parametrised successor to the combinational next-PC selector.
- Owns the registered program counter and a run/halt state machine.
- Supports two taken-branch modes:
  - PC-relative: signed offset taken from the instruction.
  - Absolute: target read from a small writable jump-target LUT.
- Sits between fetch (instruction memory address) and decode/ALU (supplies branch, zero, halt). Also counts executed instructions for the test harness.

---
 rtl/pc_ctrl.sv | 126 ++++++++++++
 tb/tb_pc_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/pc_ctrl.sv
// Program-counter controller: registered PC with an IDLE/RUN/HALTED sequencer,
// relative or LUT-based absolute branches, and a saturating retired-instruction counter.
module pc_ctrl #(
    parameter int PC_W      = 32,
    parameter int INSTR_W   = 9,
    parameter int OFF_W     = 7,
    parameter int LUT_DEPTH = 16,
    parameter int START_PC  = 0,
    parameter int CNT_W     = 16,
    localparam int LUT_AW   = (LUT_DEPTH > 1) ? $clog2(LUT_DEPTH) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stall,
    input  logic               halt,
    input  logic               branch,
    input  logic               zero,
    input  logic               abs_mode,
    input  logic [INSTR_W-1:0] instruction,
    input  logic               lut_we,
    input  logic [LUT_AW-1:0]  lut_waddr,
    input  logic [PC_W-1:0]    lut_wdata,
    output logic [PC_W-1:0]    pc,
    output logic               running,
    output logic               done,
    output logic               branch_taken,
    output logic [CNT_W-1:0]   retired
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED} state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              taken_q, taken_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic [PC_W-1:0]   lut_q [LUT_DEPTH];

    logic [LUT_AW-1:0] lut_raddr;
    logic [PC_W-1:0]   lut_rdata;
    logic [PC_W-1:0]   off_sext;
    logic [PC_W-1:0]   pc_inc;
    logic [CNT_W-1:0]  retired_inc;

    assign lut_raddr   = instruction[LUT_AW-1:0];
    assign off_sext    = PC_W'($signed(instruction[OFF_W-1:0]));
    assign pc_inc      = pc_q + PC_W'(1);
    assign retired_inc = (retired_q == '1) ? retired_q : retired_q + CNT_W'(1);

    // Indices beyond LUT_DEPTH match no entry and therefore read as zero.
    always_comb begin
        lut_rdata = '0;
        for (int i = 0; i < LUT_DEPTH; i++) begin
            if (lut_raddr == LUT_AW'(i)) begin
                lut_rdata = lut_q[i];
            end
        end
    end

    // The read above sees the pre-edge contents, so a same-cycle write/branch uses the old entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                lut_q[i] <= '0;
            end
        end else if (lut_we) begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                if (lut_waddr == LUT_AW'(i)) begin
                    lut_q[i] <= lut_wdata;
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        taken_d   = 1'b0;
        retired_d = retired_q;
        case (state_q)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    state_d   = S_RUN;
                    pc_d      = PC_W'(START_PC);
                    retired_d = '0;
                end
            end
            S_RUN: begin
                if (halt) begin
                    state_d   = S_HALTED;
                    retired_d = retired_inc;
                end else if (!stall) begin
                    retired_d = retired_inc;
                    if (branch && zero) begin
                        taken_d = 1'b1;
                        pc_d    = abs_mode ? lut_rdata : pc_inc + off_sext;
                    end else begin
                        pc_d    = pc_inc;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pc_q      <= PC_W'(START_PC);
            taken_q   <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            taken_q   <= taken_d;
            retired_q <= retired_d;
        end
    end

    assign pc           = pc_q;
    assign running      = (state_q == S_RUN);
    assign done         = (state_q == S_HALTED);
    assign branch_taken = taken_q;
    assign retired      = retired_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed bench for pc_ctrl: one default instance plus a CNT_W=4 instance for saturation.
module tb_pc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, start, stall, halt, branch, zero, abs_mode, lut_we;
    logic [8:0]  instruction;
    logic [3:0]  lut_waddr;
    logic [31:0] lut_wdata;
    logic [31:0] pc, pc_s;
    logic        running, done, taken, running_s, done_s, taken_s;
    logic [15:0] retired;
    logic [3:0]  retired_s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pc_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .halt(halt),
        .branch(branch), .zero(zero), .abs_mode(abs_mode), .instruction(instruction),
        .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
        .pc(pc), .running(running), .done(done), .branch_taken(taken), .retired(retired)
    );

    pc_ctrl #(.CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .halt(halt),
        .branch(branch), .zero(zero), .abs_mode(abs_mode), .instruction(instruction),
        .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
        .pc(pc_s), .running(running_s), .done(done_s), .branch_taken(taken_s), .retired(retired_s)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stall = 1'b0; halt = 1'b0; branch = 1'b0;
        zero = 1'b0; abs_mode = 1'b0; lut_we = 1'b0; instruction = '0;
        lut_waddr = '0; lut_wdata = '0;
        repeat (2) step();
        rst_n = 1'b1;
        chk("reset_pc", pc, 0);
        chk("reset_running", running, 0);
        chk("reset_done", done, 0);
        chk("reset_taken", taken, 0);
        chk("reset_retired", retired, 0);
        $display("reset: pc=%0h running=%0b retired=%0d", pc, running, retired);

        start = 1'b1; step(); start = 1'b0;
        chk("start_running", running, 1);
        chk("start_pc", pc, 0);
        repeat (18) step();
        chk("run18_pc", pc, 32'h12);
        chk("run18_retired", retired, 18);
        $display("run 18: pc=%0h retired=%0d", pc, retired);

        // Asynchronous reset mid-cycle, mid-run
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_pc", pc, 0);
        chk("async_rst_running", running, 0);
        chk("async_rst_retired", retired, 0);
        chk("async_rst_done", done, 0);
        step(); rst_n = 1'b1;
        step();
        chk("idle_hold_pc", pc, 0);
        chk("idle_hold_running", running, 0);
        $display("async reset: pc=%0h running=%0b", pc, running);

        start = 1'b1; step(); start = 1'b0;
        chk("restart_running", running, 1);
        chk("restart_pc", pc, 0);
        repeat (5) step();
        chk("plain5_pc", pc, 5);
        chk("plain5_retired", retired, 5);
        chk("sat_retired_5", retired_s, 5);

        branch = 1'b1; zero = 1'b1; instruction = 9'h07D;
        step(); branch = 1'b0; zero = 1'b0;
        chk("rel_m3_pc", pc, 3);
        chk("rel_m3_taken", taken, 1);
        chk("rel_m3_retired", retired, 6);
        $display("rel branch -3: pc=%0h taken=%0b", pc, taken);
        step();
        chk("after_rel_taken", taken, 0);
        chk("after_rel_pc", pc, 4);

        branch = 1'b1; zero = 1'b0; step(); branch = 1'b0;
        chk("nottaken_pc", pc, 5);
        chk("nottaken_taken", taken, 0);
        chk("nottaken_retired", retired, 8);

        lut_we = 1'b1; lut_waddr = 4'd4; lut_wdata = 32'h100;
        step(); lut_we = 1'b0;
        chk("lut_wr_pc", pc, 6);
        branch = 1'b1; zero = 1'b1; abs_mode = 1'b1; instruction = 9'h004;
        step();
        chk("abs_pc", pc, 32'h100);
        chk("abs_taken", taken, 1);
        lut_we = 1'b1; lut_wdata = 32'h200;
        step(); lut_we = 1'b0;
        chk("abs_collide_old", pc, 32'h100);
        step();
        chk("abs_repeat_new", pc, 32'h200);
        chk("abs_retired", retired, 12);
        $display("abs branches: pc=%0h retired=%0d", pc, retired);
        abs_mode = 1'b0;

        stall = 1'b1; branch = 1'b1; zero = 1'b1;
        step();
        chk("stall_pc", pc, 32'h200);
        chk("stall_retired", retired, 12);
        chk("stall_taken", taken, 0);
        halt = 1'b1;
        step(); halt = 1'b0; stall = 1'b0; branch = 1'b0; zero = 1'b0;
        chk("halt_done", done, 1);
        chk("halt_running", running, 0);
        chk("halt_pc", pc, 32'h200);
        chk("halt_retired", retired, 13);
        step();
        chk("halted_hold_pc", pc, 32'h200);
        chk("halted_hold_done", done, 1);
        $display("halt: done=%0b pc=%0h retired=%0d", done, pc, retired);
        start = 1'b1; step(); start = 1'b0;
        chk("resume_running", running, 1);
        chk("resume_pc", pc, 0);
        chk("resume_retired", retired, 0);

        lut_we = 1'b1; lut_waddr = 4'd2; lut_wdata = 32'hFFFF_FFFF;
        step(); lut_we = 1'b0;
        branch = 1'b1; zero = 1'b1; abs_mode = 1'b1; instruction = 9'h002;
        step(); branch = 1'b0; zero = 1'b0; abs_mode = 1'b0;
        chk("wrap_set_pc", pc, 32'hFFFF_FFFF);
        step();
        chk("wrap_inc_pc", pc, 0);
        branch = 1'b1; zero = 1'b1; instruction = 9'h07F;
        step();
        chk("rel_m1_pc", pc, 0);
        instruction = 9'h07E;
        step(); branch = 1'b0; zero = 1'b0;
        chk("rel_m2_pc", pc, 32'hFFFF_FFFF);
        chk("wrap_retired", retired, 5);
        $display("wrap: pc=%0h retired=%0d", pc, retired);

        repeat (20) step();
        chk("sat_retired_15", retired_s, 15);
        chk("main_retired_25", retired, 25);
        step();
        chk("sat_hold_15", retired_s, 15);
        $display("saturation: retired_s=%0d retired=%0d", retired_s, retired);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
